// File: rtl/twiddle_feeder.sv
// Twiddle-factor sequencer for NTT/INTT passes: steps stage/beat counters, reads the twiddle ROM
// and presents packed 24-bit w words on a valid/ready handshake. Inverse support: TWIDDLE_FEEDER_INTT_EN.
module twiddle_feeder #(
    parameter int unsigned ROM_AW = 9,
    parameter int unsigned D_BASE = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              inv,
    output logic              busy,
    output logic              done,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr_a,
    output logic [ROM_AW-1:0] rom_addr_b,
    input  logic [22:0]       rom_q_a,
    input  logic [22:0]       rom_q_b,
    output logic [23:0]       w,
    output logic [1:0]        sel_a,
    output logic              mul_Red_mode,
    output logic [2:0]        stage,
    output logic              w_valid,
    input  logic              w_ready
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [ROM_AW-1:0] LP_DBASE = ROM_AW'(D_BASE);

    logic [1:0] r_state;
    logic       r_mode;
    logic       r_done;
    logic       r_wvalid;
    logic [2:0] r_sidx;
    logic [2:0] r_stage_q;
    logic [6:0] r_beat;
`ifdef TWIDDLE_FEEDER_INTT_EN
    logic       r_inv;
`endif

    logic       w_adv;
    logic       w_issue;
    logic       w_hs;
    logic       w_last_beat;
    logic       w_last_stage;
    logic [2:0] w_s_last;
    logic [2:0] w_s;
    logic [2:0] w_shift;
    logic [6:0] w_j_b;
    logic [8:0] w_pow;
    logic [8:0] w_grp_a;
    logic [8:0] w_grp_b;
    logic [8:0] w_k_a;
    logic [8:0] w_k_b;
    logic       w_unused;

    assign w_adv        = !r_wvalid || w_ready;
    assign w_issue      = (r_state == S_RUN) && w_adv;
    assign w_hs         = r_wvalid && w_ready;
    assign w_s_last     = r_mode ? 3'd7 : 3'd6;
    assign w_last_beat  = r_mode ? (r_beat == 7'd127) : (r_beat == 7'd63);
    assign w_last_stage = (r_sidx == w_s_last);

    // r_sidx counts stages in issue order; the actual stage is reversed for inverse passes
`ifdef TWIDDLE_FEEDER_INTT_EN
    assign w_s = r_inv ? (w_s_last - r_sidx) : r_sidx;
`else
    assign w_s = r_sidx;
`endif

    assign w_j_b   = {1'b1, r_beat[5:0]};
    assign w_shift = 3'd7 - w_s;
    assign w_pow   = 9'd1 << w_s;
    assign w_grp_a = {2'b00, r_beat} >> w_shift;
    assign w_grp_b = {2'b00, w_j_b} >> w_shift;

`ifdef TWIDDLE_FEEDER_INTT_EN
    assign w_k_a = r_inv ? ((w_pow << 1) - 9'd1 - w_grp_a) : (w_pow + w_grp_a);
    assign w_k_b = r_inv ? ((w_pow << 1) - 9'd1 - w_grp_b) : (w_pow + w_grp_b);
    assign sel_a = ((r_state != S_IDLE) && r_inv) ? 2'b10 : 2'b00;
    assign w_unused = ^{rom_q_b[22:12]};
`else
    assign w_k_a = w_pow + w_grp_a;
    assign w_k_b = w_pow + w_grp_b;
    assign sel_a = 2'b00;
    assign w_unused = ^{rom_q_b[22:12], inv};
`endif

    assign rom_en     = w_issue;
    assign rom_addr_a = !w_issue ? '0 :
                        r_mode   ? (LP_DBASE + ROM_AW'(w_k_a)) : ROM_AW'(w_k_a);
    assign rom_addr_b = (!w_issue || r_mode) ? '0 : ROM_AW'(w_k_b);

    // ROM output holds while rom_en is low, so w stays stable through a stall
    assign w = !r_wvalid ? '0 :
               r_mode    ? {1'b0, rom_q_a[22:12], rom_q_a[11:0]} :
                           {rom_q_a[11:0], rom_q_b[11:0]};

    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign mul_Red_mode = r_mode;
    assign stage        = r_stage_q;
    assign w_valid      = r_wvalid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_done    <= 1'b0;
            r_wvalid  <= 1'b0;
            r_sidx    <= '0;
            r_stage_q <= '0;
            r_beat    <= '0;
`ifdef TWIDDLE_FEEDER_INTT_EN
            r_inv     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !r_done) begin
                        r_state <= S_RUN;
                        r_mode  <= mode;
                        r_sidx  <= '0;
                        r_beat  <= '0;
`ifdef TWIDDLE_FEEDER_INTT_EN
                        r_inv   <= inv;
`endif
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_stage_q <= w_s;
                        if (w_last_beat) begin
                            r_beat <= '0;
                            if (w_last_stage) begin
                                r_sidx  <= '0;
                                r_state <= S_DRAIN;
                            end else begin
                                r_sidx <= r_sidx + 3'd1;
                            end
                        end else begin
                            r_beat <= r_beat + 7'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_hs) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_issue) begin
                r_wvalid <= 1'b1;
            end else if (w_ready) begin
                r_wvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_twiddle_feeder.sv
// Bench for twiddle_feeder: random ROM contents and backpressure, expected beats built from the
// stage/beat/twiddle-index rules with plain integer arithmetic.
`timescale 1ns/1ps
module tb_twiddle_feeder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        inv = 1'b0;
    logic        w_ready = 1'b0;
    logic        busy, done, rom_en, sel_dummy;
    logic [8:0]  rom_addr_a, rom_addr_b;
    logic [22:0] rom_q_a = '0;
    logic [22:0] rom_q_b = '0;
    logic [23:0] w;
    logic [1:0]  sel_a;
    logic        mul_Red_mode;
    logic [2:0]  stage;
    logic        w_valid;

    logic [22:0] rom [0:383];

    int n_checks = 0;
    int n_errors = 0;

    int          exp_a[$];
    int          exp_b[$];
    int          exp_s[$];
    logic [23:0] exp_w[$];

    twiddle_feeder #(.ROM_AW(9), .D_BASE(128)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .inv(inv),
        .busy(busy), .done(done), .rom_en(rom_en),
        .rom_addr_a(rom_addr_a), .rom_addr_b(rom_addr_b),
        .rom_q_a(rom_q_a), .rom_q_b(rom_q_b),
        .w(w), .sel_a(sel_a), .mul_Red_mode(mul_Red_mode), .stage(stage),
        .w_valid(w_valid), .w_ready(w_ready)
    );

    always #5 clk = ~clk;

    assign sel_dummy = 1'b0;

    always @(posedge clk) begin
        if (rom_en) begin
            rom_q_a <= (rom_addr_a < 9'd384) ? rom[rom_addr_a] : '0;
            rom_q_b <= (rom_addr_b < 9'd384) ? rom[rom_addr_b] : '0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int tw_k(input int s, input int j, input bit iv);
        int grp;
        grp = j / (2 ** (7 - s));
        return iv ? ((2 ** (s + 1)) - 1 - grp) : ((2 ** s) + grp);
    endfunction

    task automatic build_model(input bit m, input bit iv);
        int ns;
        int nb;
        ns = m ? 8 : 7;
        nb = m ? 128 : 64;
        exp_a.delete(); exp_b.delete(); exp_s.delete(); exp_w.delete();
        for (int si = 0; si < ns; si++) begin
            int s;
            s = iv ? (ns - 1 - si) : si;
            for (int b = 0; b < nb; b++) begin
                int a;
                int bb;
                if (m) begin
                    a  = 128 + tw_k(s, b, iv);
                    bb = 0;
                    exp_w.push_back({1'b0, rom[a]});
                end else begin
                    a  = tw_k(s, b, iv);
                    bb = tw_k(s, b + 64, iv);
                    exp_w.push_back({rom[a][11:0], rom[bb][11:0]});
                end
                exp_a.push_back(a);
                exp_b.push_back(bb);
                exp_s.push_back(s);
            end
        end
    endtask

    task automatic check_quiet_outputs();
        check("q_busy", busy, 0);
        check("q_done", done, 0);
        check("q_rom_en", rom_en, 0);
        check("q_addr_a", rom_addr_a, 0);
        check("q_addr_b", rom_addr_b, 0);
        check("q_w", w, 0);
        check("q_sel_a", sel_a, 0);
        check("q_mul_mode", mul_Red_mode, 0);
        check("q_stage", stage, 0);
        check("q_w_valid", w_valid, 0);
    endtask

    task automatic run_pass(input bit m, input bit iv, input int stall_at, input int rst_at,
                            input bit rnd_ready);
        bit         iv_eff;
        int         total, ni, nh, c, last_hs, stall_left, ndone;
        bit         stalled;
        logic [1:0] exp_sel;
`ifdef TWIDDLE_FEEDER_INTT_EN
        iv_eff = iv;
`else
        iv_eff = 1'b0;
`endif
        build_model(m, iv_eff);
        total = exp_a.size();
        exp_sel = iv_eff ? 2'b10 : 2'b00;
        ni = 0; nh = 0; last_hs = 0; stall_left = 0; stalled = 0; ndone = 0;

        @(negedge clk);
        start = 1'b1; mode = m; inv = iv; w_ready = 1'b1;
        for (c = 1; c <= 6000 && ndone == 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            mode  = 1'($urandom);
            inv   = 1'($urandom);
            if (stall_left > 0) begin
                w_ready = 1'b0;
                stall_left--;
            end else if (!stalled && stall_at >= 0 && nh == stall_at) begin
                w_ready = 1'b0;
                stall_left = 4;
                stalled = 1'b1;
            end else begin
                w_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end

            if (rst_at >= 0 && nh == rst_at) begin
                rst = 1'b0;
                #1;
                check_quiet_outputs();
                @(negedge clk);
                rst = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    #1;
                    check("rst_no_done", done, 0);
                    check("rst_idle", busy, 0);
                end
                return;
            end

            #1;
            if (c == 1) begin
                check("lat_busy_c1", busy, 1);
                check("lat_issue_c1", rom_en, 1);
                check("lat_wvalid_c1", w_valid, 0);
            end
            if (c == 2) check("lat_wvalid_c2", w_valid, 1);
            if (busy) begin
                check("mul_mode", mul_Red_mode, 32'(m));
                check("sel_a", sel_a, exp_sel);
            end

            if (rom_en) begin
                if (ni < total) begin
                    check("addr_a", rom_addr_a, exp_a[ni]);
                    check("addr_b", rom_addr_b, exp_b[ni]);
                    if (!m && !iv_eff && ni == 0)   begin check("k_b0_a", rom_addr_a, 1);   check("k_b0_b", rom_addr_b, 1);   end
                    if (!m && !iv_eff && ni == 384) begin check("k_s6b0_a", rom_addr_a, 64); check("k_s6b0_b", rom_addr_b, 96); end
                    if (!m && !iv_eff && ni == 447) begin check("k_s6b63_a", rom_addr_a, 95); check("k_s6b63_b", rom_addr_b, 127); end
                    if (m && !iv_eff && ni == 1023) begin check("d_last_a", rom_addr_a, 383); check("d_last_b", rom_addr_b, 0); end
                    if (m && iv_eff && ni == 0)     check("di_first_a", rom_addr_a, 383);
                    if (m && iv_eff && ni == 1023)  check("di_last_a", rom_addr_a, 129);
                end else begin
                    check("extra_issue", ni, total);
                end
                ni++;
            end

            if (w_valid && w_ready) begin
                if (nh < total) begin
                    check("beat_w", w, exp_w[nh]);
                    check("beat_stage", stage, exp_s[nh]);
                    if (m && !iv_eff && nh == 1023) check("d_last_w", w, 24'h7FFFFF);
                    if (m && iv_eff && nh == 0)     check("di_first_stage", stage, 7);
                    if (m && iv_eff && nh == 1023)  check("di_last_stage", stage, 0);
                end else begin
                    check("extra_beat", nh, total);
                end
                nh++;
                last_hs = c;
            end else if (w_valid) begin
                check("stall_rom_en", rom_en, 0);
                if (nh < total) begin
                    check("stall_w", w, exp_w[nh]);
                    check("stall_stage", stage, exp_s[nh]);
                end
            end

            if (done) begin
                check("done_lat", c, last_hs + 1);
                check("done_busy", busy, 0);
                ndone++;
            end
        end

        if (ndone == 0) check("timeout_done", 0, 1);
        check("hs_count", nh, total);
        check("issue_count", ni, total);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("single_done", done, 0);
            check("post_busy", busy, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 384; i++) rom[i] = 23'($urandom);
        rom[383] = 23'h7FFFFF;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_quiet_outputs();
        @(negedge clk);
        rst = 1'b1;

        run_pass(1'b0, 1'b0, -1, -1, 1'b0);
        run_pass(1'b1, 1'b0, -1, -1, 1'b0);
        run_pass(1'b1, 1'b1, -1, -1, 1'b0);
        run_pass(1'b0, 1'b0, 100, -1, 1'b0);
        run_pass(1'b0, 1'b0, -1, 50, 1'b0);
        run_pass(1'b0, 1'b0, -1, -1, 1'b0);
        run_pass(1'b0, 1'b1, -1, -1, 1'b0);
        run_pass(1'b0, 1'($urandom), -1, -1, 1'b1);
        run_pass(1'b1, 1'($urandom), -1, -1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/twiddle_feeder.md
# twiddle_feeder

Twiddle-factor sequencer that drives the `w`, `sel_a` and `mul_Red_mode` operands of the modular multiply-and-reduce unit during a full NTT or INTT pass.
- Steps stage and beat counters.
- Reads a shared twiddle ROM through two synchronous read ports.
- Packs the ROM words into the 24-bit `w` format the multiplier expects: two 12-bit Kyber twiddles, or one 23-bit Dilithium twiddle split into high and low halves.
- Presents each beat on a valid/ready handshake, so the datapath can stall it.

## Interface
Parameters:
- ROM_AW, 9: ROM address width. Kyber region is addresses 0..127; Dilithium region is 128..383.
- D_BASE, 128: base address of the Dilithium region.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a pass. Sampled only in IDLE.
- mode  in  1  0 = Kyber (K_redu), 1 = Dilithium (D_redu). Sampled at start.
- inv  in  1  0 = forward NTT, 1 = inverse. Sampled at start.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse when the last beat is accepted.
- rom_en  out  1  ROM read enable. ROM output holds while this is low.
- rom_addr_a  out  ROM_AW  port A address.
- rom_addr_b  out  ROM_AW  port B address.
- rom_q_a  in  23  port A data, valid 1 cycle after `rom_en`.
- rom_q_b  in  23  port B data, valid 1 cycle after `rom_en`.
- w  out  24  packed twiddle word.
- sel_a  out  2  2'b10 in an inverse pass, 2'b00 otherwise.
- mul_Red_mode  out  1  registered copy of `mode`.
- stage  out  3  stage index of the beat currently on `w`.
- w_valid  out  1  `w` holds a beat.
- w_ready  in  1  consumer accepts the beat.

## Operation
FSM:
- IDLE -> RUN on `start`.
- RUN -> DRAIN when the last address is issued.
- DRAIN -> IDLE when the last beat is accepted.
- `start` outside IDLE is ignored.

Stages and beats:
- Kyber: 7 stages, 64 beats each (448 total). Each beat carries two butterflies, j = b and j = b+64.
- Dilithium: 8 stages, 128 beats each (1024 total). Each beat carries one butterfly, j = b.
- Forward pass: stage order s = 0 upward. Inverse pass: s = S-1 downward.
- Beat b counts upward within every stage.

Twiddle index:
- group = j >> (7-s).
- Forward: k = 2^s + group.
- Inverse: k = 2^(s+1) - 1 - group.

ROM addresses:
- Kyber: `rom_addr_a` = k(j=b), `rom_addr_b` = k(j=b+64).
- Dilithium: `rom_addr_a` = D_BASE + k, `rom_addr_b` = 0.

Packing (combinational from ROM data):
- Kyber: `w` = {rom_q_a[11:0], rom_q_b[11:0]}.
- Dilithium: `w` = {1'b0, rom_q_a[22:12], rom_q_a[11:0]}.

Address issue:
- adv = !w_valid | w_ready.
- An address issues (`rom_en` = 1) in RUN only when adv = 1.
- On issue, the counters step to the next beat.

## Timing
- Reset: all outputs 0. FSM goes to IDLE, counters clear.
- Reset mid-pass aborts immediately with no `done`. The next `start` begins a fresh pass.
- Cycle 0: `start` high in IDLE.
- Cycle 1: `busy` = 1, first address issued.
- Cycle 2: `w_valid` = 1 with the first beat on `w`. First-beat latency is 2 cycles after `start`.
- With `w_ready` held at 1, one beat is delivered per cycle with no bubbles.
- Stall (`w_valid` && !`w_ready`):
  - `rom_en` = 0.
  - `w`, `stage` and the counters hold.
  - No beat is dropped or duplicated.
- `w_valid` falls in the cycle after a handshake only if no address was issued in the handshake cycle.
- `done` is asserted in the cycle after the last handshake. `busy` falls in that same cycle.
- A new `start` is accepted in the cycle after `done`.
- `mul_Red_mode` and `sel_a` are stable for the whole pass, from cycle 1 until `busy` falls.

## Configuration
- Macro: `TWIDDLE_FEEDER_INTT_EN`.
- Defined: `inv` is honoured as described, including reversed stage order, inverse index and `sel_a` = 2'b10.
- Undefined:
  - `inv` is ignored and every pass is forward.
  - `sel_a` is constant 2'b00.
  - The inverse index logic is not synthesized.

## Test plan
- Kyber forward, `w_ready` = 1:
  - Beat 0: addresses a = 1, b = 1.
  - Stage 6, beat 0: a = 64, b = 96.
  - Stage 6, beat 63: a = 95, b = 127.
  - Exactly 448 handshakes, then one `done` pulse.
- Dilithium forward:
  - Stage 7, beat 127: `rom_addr_a` = 383, `rom_addr_b` = 0.
  - With `rom_q_a` = 23'h7FFFFF, `w` = 24'h7FFFFF.
  - `mul_Red_mode` = 1. 1024 beats total.
- Dilithium inverse:
  - First beat: `stage` = 7, `rom_addr_a` = 383, `sel_a` = 2'b10.
  - Last beat: `stage` = 0, `rom_addr_a` = 129.
- Backpressure: drop `w_ready` for 5 cycles at Kyber beat 100.
  - `w` and `stage` hold, `rom_en` = 0.
  - Still 448 unique beats in order.
- Reset mid-pass: deassert `rst` at beat 50.
  - All outputs go to 0 and no `done` pulse occurs.
  - A following `start` restarts at address 1.
- Without `TWIDDLE_FEEDER_INTT_EN`, a Kyber pass with `inv` = 1 gives the same address sequence as the forward pass and `sel_a` = 2'b00.
